param_rr_arbiter: RTL
=====================

Name: param_rr_arbiter

Overview:
N-requester arbiter with a registered one-hot grant, selectable per-cycle between fixed-priority and round-robin modes. The grant is held while the owner keeps requesting, and a hold-time limit forces hand-off under contention. It generalises the team's 4-channel fixed-priority arbiter for shared-resource access (bus, memory port) in larger subsystems.

Parameters:
N, 4, number of requesters (2..32)
MAX_HOLD, 4, max consecutive grant cycles while others request; 0 = unlimited (pure lock until release)
IDW, $clog2(N) (min 1), width of gnt_id; derived, not overridden

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  N  request vector, bit i = requester i
mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
gnt  output  N  registered one-hot grant, all-zero when idle
gnt_id  output  IDW  index of current owner, valid when gnt_valid=1
gnt_valid  output  1  high when gnt is non-zero

Behaviour:
- Reset (async, reset=0): gnt=0, gnt_id=0, gnt_valid=0, rr pointer ptr=0, hold_cnt=0, state IDLE. Outputs change immediately, without waiting for clk.
- All outputs registered. Grant appears on the first rising edge at which req is sampled non-zero, giving 1-cycle latency.
- States:
  - IDLE (no owner): if req!=0, arbitrate, go to GRANT, hold_cnt=0; else stay.
  - GRANT (owner k):
    - req[k]=0 (release): arbitrate among req this edge. Result goes to GRANT with new owner, or to IDLE with gnt=0. No bubble cycle.
    - req[k]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and (req & ~bit k)!=0 (timeout): arbitrate among req excluding k; new owner, hold_cnt=0.
    - Otherwise keep owner. hold_cnt increments, saturating at MAX_HOLD-1.
    - If owner is sole requester at the limit: keep grant, hold_cnt stays saturated.
- Arbitration:
  - fixed: highest set index of candidate vector.
  - rr: first set bit searching upward from ptr, wrapping N-1 -> 0.
  - mode is sampled at the arbitration edge. Changing it mid-grant does not disturb the current owner.
- ptr updates to (new_owner+1) mod N on every new grant, in both modes, so switching to rr is fair immediately.
- Fixed mode with timeout: top two requesters alternate in MAX_HOLD blocks. This is intended; lower indices starve while the top two request.
- gnt is always one-hot or zero. gnt_id and gnt_valid are consistent with gnt on the same cycle.
- req bits for non-owners changing mid-grant have no effect until the next arbitration.

Decomposition:
- Shared package arb_pkg:
  - arb_mode_e (ARB_FIXED=1'b0, ARB_RR=1'b1)
  - arb_state_e (ARB_IDLE, ARB_GRANT)
  - function onehot_to_idx
- One combinational sub-module arb_pick:
  - Inputs: cand[N], ptr[IDW], mode.
  - Outputs: pick_oh[N], pick_idx, pick_valid.
  - Implements fixed and rotating search; reused by future weighted variants.

Test Plan:
- N=4, MAX_HOLD=4, mode=0, req=4'b0101 from reset release -> next edge gnt=0100, gnt_id=2, gnt_valid=1; held while req unchanged and uncontended by timeout (bit0 only other requester: hand-off to 0001 after 4 cycles, then back to 0100 after 4).
- mode=1, req=4'b1111 held constant after reset -> gnt 0001 for 4 cycles, 0010 for 4, 0100 for 4, 1000 for 4, then 0001 (wrap).
- mode=1, req=4'b0011, owner 0; drop req[0] -> at next edge gnt=0010 with no idle cycle; then req=0 -> next edge gnt=0, gnt_valid=0.
- MAX_HOLD=0, mode=1, req=4'b1111 -> gnt=0001 held indefinitely (100 cycles checked) until req[0] drops, then gnt=0010.
- Switch mode 0->1 while owner 3 holds with req=4'b1011 -> owner 3 kept; at timeout next grant uses ptr=0, giving 0001.
- Assert reset low mid-grant (gnt=0100) between clock edges -> gnt=0, gnt_id=0, gnt_valid=0 immediately; after release with req=4'b1111, mode=1 -> first grant 0001 (ptr reset to 0).

Source files
------------

// File: rtl/param_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg: shared types and helpers for the arbiter family.
//   arb_mode_e    : per-cycle arbitration policy (fixed priority / round-robin)
//   arb_state_e   : ownership state of the grant FSM
//   idx_width     : index width for N requesters (never below 1)
//   onehot_to_idx : encode a one-hot vector (up to ARB_MAX_N bits) to an index
// ----------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_MAX_N = 32;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // OR-reduction encoder: exact for one-hot input, zero for all-zero input.
    function automatic logic [4:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/param_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// param_rr_arbiter_if: request/grant bundle between requesters and arbiter.
//   req       : request vector, bit i = requester i
//   mode      : 0 = fixed priority, 1 = round-robin
//   gnt       : one-hot grant, zero when idle
//   gnt_id    : index of current owner (meaningful when gnt_valid=1)
//   gnt_valid : grant present
// master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface param_rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int N = 4
);
    localparam int IDW = idx_width(N);

    logic [N-1:0]   req;
    logic           mode;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;

    modport master (output req, mode, input gnt, gnt_id, gnt_valid);
    modport slave  (input req, mode, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/param_rr_arbiter_pick.sv
// ----------------------------------------------------------------------------
// arb_pick: combinational winner selection over a candidate vector.
//   cand       : candidate requesters
//   ptr        : round-robin start index (first index searched)
//   mode       : 0 = highest set index wins, 1 = first set bit from ptr upward
//   pick_oh    : one-hot winner (zero if no candidate)
//   pick_idx   : winner index
//   pick_valid : at least one candidate
// ----------------------------------------------------------------------------
module arb_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = idx_width(N)
) (
    input  logic [N-1:0]   cand,
    input  logic [IDW-1:0] ptr,
    input  logic           mode,
    output logic [N-1:0]   pick_oh,
    output logic [IDW-1:0] pick_idx,
    output logic           pick_valid
);

    always_comb begin
        int j;
        j       = 0;
        pick_oh = '0;
        if (mode == ARB_FIXED) begin
            // Ascending scan: the last hit, i.e. the highest index, survives.
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    pick_oh    = '0;
                    pick_oh[i] = 1'b1;
                end
            end
        end else begin
            // Scan offsets from far to near so the hit closest to ptr survives.
            for (int k = N - 1; k >= 0; k--) begin
                j = (int'(ptr) + k) % N;
                if (cand[j]) begin
                    pick_oh    = '0;
                    pick_oh[j] = 1'b1;
                end
            end
        end
    end

    assign pick_valid = |cand;
    assign pick_idx   = IDW'(onehot_to_idx(ARB_MAX_N'(pick_oh)));

endmodule

// File: rtl/param_rr_arbiter.sv
// ----------------------------------------------------------------------------
// param_rr_arbiter: N-requester arbiter with registered one-hot grant.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of param_rr_arbiter_if (req, mode in; gnt, gnt_id,
//           gnt_valid out, all registered)
// The owner keeps the grant while it requests; with MAX_HOLD != 0 it is forced
// to hand off after MAX_HOLD consecutive cycles if anyone else is requesting.
// ----------------------------------------------------------------------------
module param_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    param_rr_arbiter_if.slave bus
);

    localparam int IDW = idx_width(N);
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    // With MAX_HOLD = 0 the counter is never consulted and simply stays at 0.
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_e     state;
    logic [IDW-1:0] ptr;
    logic [HCW-1:0] hold_cnt;

    logic [N-1:0]   cand;
    logic [N-1:0]   pick_oh;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] next_ptr;
    logic           pick_valid;
    logic           owner_req;
    logic           others_req;
    logic           timeout;
    logic           rearb;

    // gnt is one-hot (or zero), so masking req with it tests the owner's bit.
    assign owner_req  = |(bus.req & bus.gnt);
    assign others_req = |(bus.req & ~bus.gnt);
    assign timeout    = (MAX_HOLD != 0) && owner_req && (hold_cnt == HOLD_LAST) && others_req;
    assign rearb      = (state == ARB_IDLE) || !owner_req || timeout;
    // On timeout the current owner is excluded from the contest.
    assign cand       = timeout ? (bus.req & ~bus.gnt) : bus.req;
    assign next_ptr   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;

    arb_pick #(.N(N), .IDW(IDW)) u_pick (
        .cand       (cand),
        .ptr        (ptr),
        .mode       (bus.mode),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARB_IDLE;
            bus.gnt       <= '0;
            bus.gnt_id    <= '0;
            bus.gnt_valid <= 1'b0;
            ptr           <= '0;
            hold_cnt      <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state         <= ARB_GRANT;
                        bus.gnt       <= pick_oh;
                        bus.gnt_id    <= pick_idx;
                        bus.gnt_valid <= 1'b1;
                        ptr           <= next_ptr;
                        hold_cnt      <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (rearb) begin
                        // Release or timeout: hand off in the same edge, no bubble.
                        if (pick_valid) begin
                            bus.gnt       <= pick_oh;
                            bus.gnt_id    <= pick_idx;
                            bus.gnt_valid <= 1'b1;
                            ptr           <= next_ptr;
                        end else begin
                            state         <= ARB_IDLE;
                            bus.gnt       <= '0;
                            bus.gnt_id    <= '0;
                            bus.gnt_valid <= 1'b0;
                        end
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
